p_if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue. It assembles instructions from a byte-wide memory read port, one byte request per cycle, pipelined. Completed instructions are buffered in a `QUEUE_DEPTH`-entry FIFO and handed to decode over a valid/ready handshake. It sits between the memory controller's instruction port and `p_id`, and it flushes and redirects on a branch/jump from the execute stage.

---
 rtl/p_if_prefetch_pkg.sv | 12 +
 rtl/p_if_prefetch_queue.sv | 72 +++++++
 rtl/p_if_prefetch.sv | 146 ++++++++++++++
 tb/tb_p_if_prefetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and default sizing.
package p_if_prefetch_pkg;

    typedef enum logic {
        IF_IDLE  = 1'b0,
        IF_FETCH = 1'b1
    } if_state_t;

    localparam int DEFAULT_INST_BYTES  = 4;
    localparam int DEFAULT_QUEUE_DEPTH = 4;

endpackage

// File: rtl/p_if_prefetch_queue.sv
// Synchronous FIFO with flush and a registered head entry, so consumers see no
// combinational path from pop to the head data.
module fetch_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     head_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_inc;
    logic [CW-1:0] count_d;
    logic [W-1:0]  head_d;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_inc  = rd_ptr + AW'(1);
    assign count_d = count + CW'(push_ok) - CW'(pop_ok);

    // Next head: the entry behind the popped one, or the pushed word when it
    // becomes the only entry.
    always_comb begin
        head_d = head_data;
        if (pop_ok) begin
            if (count > CW'(1)) head_d = mem[rd_inc];
            else if (push_ok)   head_d = push_data;
        end else if (push_ok && empty) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_data  <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_inc;
            count      <= count_d;
            head_data  <= head_d;
            head_valid <= (count_d != '0);
        end
    end

endmodule

// File: rtl/p_if_prefetch.sv
// Instruction fetch stage: assembles instructions from a byte-wide read port and
// buffers them in a prefetch queue for decode; flushes and redirects on jumps.
module p_if_prefetch
    import p_if_prefetch_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               INST_BYTES  = DEFAULT_INST_BYTES,
    parameter int               QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter int               BIG_ENDIAN  = 0,
    parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     jump_in,
    input  logic [XLEN-1:0]          jump_addr,
    output logic [XLEN-1:0]          mem_addr,
    output logic                     mem_re,
    input  logic                     mem_busy,
    input  logic [7:0]               mem_din,
    output logic                     inst_valid,
    output logic [8*INST_BYTES-1:0]  inst,
    output logic [XLEN-1:0]          inst_pc,
    input  logic                     id_ready,
    output if_state_t                dbg_state
);

    localparam int              IW        = 8 * INST_BYTES;
    localparam int              CW        = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
    localparam int              CQ        = $clog2(QUEUE_DEPTH) + 1;
    localparam int              QW        = CQ + 1;
    localparam logic [QW-1:0]   DEPTH_Q   = QW'(QUEUE_DEPTH);
    localparam logic [CW-1:0]   LAST_LANE = CW'(INST_BYTES - 1);

    if_state_t                     state_q, state_d;
    logic [XLEN-1:0]               fetch_pc, asm_pc;
    logic [CW-1:0]                 byte_cnt, cap_lane;
    logic                          cap_pending, cap_last, discard, done_pending;
    logic [INST_BYTES-1:0][7:0]    asm_q, asm_next;
    logic [IW-1:0]                 push_inst;
    logic [IW+XLEN-1:0]            head;
    logic [CQ-1:0]                 fifo_count;
    logic [QW-1:0]                 occ;
    logic q_full, q_empty, jump, accept, last_req, inflight, slot_free, cont_free;
    logic cap_valid, cap_done, push, pop;

    // Handshake: decode takes the head when inst_valid && id_ready at a rising
    // edge; inst_valid never depends on id_ready within the same cycle.
    assign jump      = jump_in && rdy_in;
    assign accept    = mem_re && !mem_busy;
    assign last_req  = (byte_cnt == LAST_LANE);
    assign cap_valid = cap_pending && !discard;
    assign cap_done  = cap_valid && cap_last;
    assign inflight  = cap_done || done_pending;
    assign occ       = QW'(fifo_count) + QW'(inflight);
    assign slot_free = occ < DEPTH_Q;
    assign cont_free = (occ + QW'(1)) < DEPTH_Q;
    assign push      = !jump && rdy_in && !q_full && inflight;
    assign pop       = !jump && rdy_in && !q_empty && id_ready;
    assign inst      = head[IW+XLEN-1:XLEN];
    assign inst_pc   = head[XLEN-1:0];

    always_ff @(posedge clk_in) begin
        if (!rst_in) state_q <= IF_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (jump)                    state_d = IF_FETCH;
        else if (accept && last_req) state_d = cont_free ? IF_FETCH : IF_IDLE;
        else if (accept)             state_d = IF_FETCH;
    end

    // IDLE issues byte 0 itself once a slot is free, so no bubble on entry.
    always_comb begin
        mem_re    = rst_in && rdy_in && ((state_q == IF_FETCH) || slot_free);
        mem_addr  = fetch_pc + XLEN'(byte_cnt);
        dbg_state = state_q;
    end

    always_comb begin
        asm_next = asm_q;
        if (cap_valid) asm_next[cap_lane] = mem_din;
    end

    always_comb begin
        push_inst = asm_next;
        if (BIG_ENDIAN != 0) begin
            for (int k = 0; k < INST_BYTES; k++) push_inst[8*(INST_BYTES-1-k) +: 8] = asm_next[k];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            fetch_pc     <= RESET_PC;
            asm_pc       <= '0;
            byte_cnt     <= '0;
            cap_pending  <= 1'b0;
            cap_lane     <= '0;
            cap_last     <= 1'b0;
            discard      <= 1'b0;
            done_pending <= 1'b0;
            asm_q        <= '0;
        end else begin
            // A byte owed from last cycle lands even while rdy_in is low.
            cap_pending <= accept;
            cap_lane    <= byte_cnt;
            cap_last    <= last_req;
            discard     <= jump;
            asm_q       <= asm_next;
            if (jump || push) done_pending <= 1'b0;
            else if (cap_done) done_pending <= 1'b1;
            if (jump) begin
                fetch_pc <= jump_addr;
                byte_cnt <= '0;
            end else if (accept) begin
                if (byte_cnt == '0) asm_pc <= fetch_pc;
                if (last_req) begin
                    byte_cnt <= '0;
                    fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
                end else begin
                    byte_cnt <= byte_cnt + CW'(1);
                end
            end
        end
    end

    fetch_queue #(
        .W     (IW + XLEN),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .flush      (jump),
        .push       (push),
        .push_data  ({push_inst, asm_pc}),
        .pop        (pop),
        .head_data  (head),
        .head_valid (inst_valid),
        .full       (q_full),
        .empty      (q_empty),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_p_if_prefetch.sv
// Directed bench for p_if_prefetch: default little-endian instance plus a
// big-endian, 2-byte instance starting near the top of the address space.
module tb_p_if_prefetch;
    import p_if_prefetch_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        jump_in = 1'b0;
    logic [31:0] jump_addr = '0;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_busy = 1'b0;
    logic [7:0]  mem_din = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        id_ready = 1'b0;
    if_state_t   dbg_state;

    logic        b_jump_in = 1'b0;
    logic [31:0] b_jump_addr = '0;
    logic [31:0] b_mem_addr;
    logic        b_mem_re;
    logic        b_mem_busy = 1'b0;
    logic [7:0]  b_mem_din = '0;
    logic        b_inst_valid;
    logic [15:0] b_inst;
    logic [31:0] b_inst_pc;
    logic        b_id_ready = 1'b0;
    if_state_t   b_dbg_state;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    // Memory model: every address reads back as its low byte, one cycle later.
    always @(posedge clk_in) begin
        mem_din   <= mem_addr[7:0];
        b_mem_din <= b_mem_addr[7:0];
    end

    p_if_prefetch u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .jump_in(jump_in),
        .jump_addr(jump_addr), .mem_addr(mem_addr), .mem_re(mem_re), .mem_busy(mem_busy),
        .mem_din(mem_din), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .id_ready(id_ready), .dbg_state(dbg_state)
    );

    p_if_prefetch #(.BIG_ENDIAN(1), .INST_BYTES(2), .RESET_PC(32'hFFFF_FFFE)) u_be (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .jump_in(b_jump_in),
        .jump_addr(b_jump_addr), .mem_addr(b_mem_addr), .mem_re(b_mem_re), .mem_busy(b_mem_busy),
        .mem_din(b_mem_din), .inst_valid(b_inst_valid), .inst(b_inst), .inst_pc(b_inst_pc),
        .id_ready(b_id_ready), .dbg_state(b_dbg_state)
    );

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    // Leaves the bench in cycle 0, the first cycle with rst_in high.
    task automatic do_reset();
        rst_in = 1'b0; rdy_in = 1'b1; jump_in = 1'b0; jump_addr = '0;
        mem_busy = 1'b0; id_ready = 1'b0; b_id_ready = 1'b0;
        step();
        step();
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (6) step();
        rst_in = 1'b0;
        step();
        #1;
        n_checks++;
        if (mem_re !== 1'b0) begin n_err++; $display("FAIL reset_mem_re: got %0b want 0", mem_re); end
        n_checks++;
        if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++;
        if ({inst_valid, inst, inst_pc} !== 65'h0) begin
            n_err++; $display("FAIL reset_outputs: got valid=%0b inst=%h pc=%h want all 0", inst_valid, inst, inst_pc);
        end
        n_checks++;
        if (dbg_state !== IF_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IF_IDLE", dbg_state); end
        n_checks++;
        if (b_mem_addr !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL reset_b_mem_addr: got %h want fffffffe", b_mem_addr); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            #1;
            n_checks++;
            if ({mem_re, mem_addr} !== {1'b1, 32'(k)}) begin
                n_err++; $display("FAIL first_req%0d: got re=%0b addr=%h want re=1 addr=%h", k, mem_re, mem_addr, k);
            end
        end
        step(); #1;
        n_checks++;
        if (inst_valid !== 1'b0) begin n_err++; $display("FAIL first_early_valid: got %0b want 0 in cycle 4", inst_valid); end
        step(); #1;
        n_checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0302_0100, 32'h0}) begin
            n_err++; $display("FAIL first_inst: got valid=%0b inst=%h pc=%h want 1 03020100 0", inst_valid, inst, inst_pc);
        end
        step(); #1;
        n_checks++;
        if (inst_valid !== 1'b0) begin n_err++; $display("FAIL first_pop: got valid=%0b want 0 in cycle 6", inst_valid); end
        repeat (3) step();
        #1;
        n_checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0706_0504, 32'h4}) begin
            n_err++; $display("FAIL second_inst: got valid=%0b inst=%h pc=%h want 1 07060504 4", inst_valid, inst, inst_pc);
        end
        id_ready = 1'b0;
    endtask

    task automatic test_queue_full();
        int reqs;
        reqs = 0;
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            if (c > 0) step();
            #1;
            if (mem_re === 1'b1) reqs++;
            if (c == 16) begin
                n_checks++;
                if ({mem_re, dbg_state} !== {1'b0, IF_IDLE}) begin
                    n_err++; $display("FAIL full_stop: got re=%0b state=%0d want re=0 IF_IDLE", mem_re, dbg_state);
                end
            end
        end
        n_checks++;
        if (reqs != 16) begin n_err++; $display("FAIL full_req_count: got %0d want 16", reqs); end
        n_checks++;
        if ({mem_re, inst_valid, inst, inst_pc} !== {1'b0, 1'b1, 32'h0302_0100, 32'h0}) begin
            n_err++; $display("FAIL full_head: got re=%0b valid=%0b inst=%h pc=%h want 0 1 03020100 0", mem_re, inst_valid, inst, inst_pc);
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        #1;
        n_checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0706_0504, 32'h4}) begin
            n_err++; $display("FAIL full_pop_head: got valid=%0b inst=%h pc=%h want 1 07060504 4", inst_valid, inst, inst_pc);
        end
        n_checks++;
        if ({mem_re, mem_addr} !== {1'b1, 32'h10}) begin
            n_err++; $display("FAIL full_resume: got re=%0b addr=%h want re=1 addr=10", mem_re, mem_addr);
        end
    endtask

    task automatic test_busy();
        do_reset();
        step(); step();
        mem_busy = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            if (c > 2) step();
            if (c == 5) mem_busy = 1'b0;
            #1;
            n_checks++;
            if ({mem_re, mem_addr} !== {1'b1, 32'h2}) begin
                n_err++; $display("FAIL busy_hold_c%0d: got re=%0b addr=%h want re=1 addr=2", c, mem_re, mem_addr);
            end
        end
        step(); #1;
        n_checks++;
        if (mem_addr !== 32'h3) begin n_err++; $display("FAIL busy_next: got addr=%h want 3", mem_addr); end
        step(); #1;
        n_checks++;
        if (inst_valid !== 1'b0) begin n_err++; $display("FAIL busy_early_valid: got %0b want 0 in cycle 7", inst_valid); end
        step(); #1;
        n_checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0302_0100, 32'h0}) begin
            n_err++; $display("FAIL busy_inst: got valid=%0b inst=%h pc=%h want 1 03020100 0", inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_jump();
        do_reset();
        repeat (11) step();
        jump_in = 1'b1;
        jump_addr = 32'h100;
        #1;
        n_checks++;
        if ({inst_valid, mem_addr} !== {1'b1, 32'hB}) begin
            n_err++; $display("FAIL jump_pre: got valid=%0b addr=%h want valid=1 addr=b", inst_valid, mem_addr);
        end
        step();
        jump_in = 1'b0;
        #1;
        n_checks++;
        if ({inst_valid, mem_re, mem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_err++; $display("FAIL jump_redirect: got valid=%0b re=%0b addr=%h want 0 1 100", inst_valid, mem_re, mem_addr);
        end
        for (int c = 13; c <= 16; c++) begin
            step(); #1;
            n_checks++;
            if (inst_valid !== 1'b0) begin n_err++; $display("FAIL jump_drop_c%0d: got valid=%0b want 0", c, inst_valid); end
        end
        step(); #1;
        n_checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0302_0100, 32'h100}) begin
            n_err++; $display("FAIL jump_target: got valid=%0b inst=%h pc=%h want 1 03020100 100", inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        repeat (5) step();
        rdy_in = 1'b0;
        id_ready = 1'b1;
        for (int c = 5; c <= 9; c++) begin
            if (c > 5) step();
            #1;
            n_checks++;
            if ({mem_re, mem_addr, inst_valid, inst, inst_pc} !== {1'b0, 32'h5, 1'b1, 32'h0302_0100, 32'h0}) begin
                n_err++; $display("FAIL rdy_hold_c%0d: got re=%0b addr=%h valid=%0b inst=%h pc=%h want 0 5 1 03020100 0",
                                  c, mem_re, mem_addr, inst_valid, inst, inst_pc);
            end
        end
        step();
        rdy_in = 1'b1;
        id_ready = 1'b0;
        #1;
        n_checks++;
        if ({mem_re, mem_addr, inst_pc} !== {1'b1, 32'h5, 32'h0}) begin
            n_err++; $display("FAIL rdy_release: got re=%0b addr=%h pc=%h want 1 5 0", mem_re, mem_addr, inst_pc);
        end
        repeat (4) step();
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        #1;
        n_checks++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0706_0504, 32'h4}) begin
            n_err++; $display("FAIL rdy_resume_inst: got valid=%0b inst=%h pc=%h want 1 07060504 4", inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_big_endian();
        do_reset();
        #1;
        n_checks++;
        if ({b_mem_re, b_mem_addr} !== {1'b1, 32'hFFFF_FFFE}) begin
            n_err++; $display("FAIL be_req0: got re=%0b addr=%h want 1 fffffffe", b_mem_re, b_mem_addr);
        end
        step(); step(); #1;
        n_checks++;
        if ({b_mem_re, b_mem_addr} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL be_wrap: got re=%0b addr=%h want 1 0", b_mem_re, b_mem_addr);
        end
        step(); #1;
        n_checks++;
        if ({b_inst_valid, b_inst, b_inst_pc} !== {1'b1, 16'hFEFF, 32'hFFFF_FFFE}) begin
            n_err++; $display("FAIL be_first: got valid=%0b inst=%h pc=%h want 1 feff fffffffe", b_inst_valid, b_inst, b_inst_pc);
        end
        step(); step();
        b_id_ready = 1'b1;
        step();
        b_id_ready = 1'b0;
        #1;
        n_checks++;
        if ({b_inst_valid, b_inst, b_inst_pc} !== {1'b1, 16'h0001, 32'h0}) begin
            n_err++; $display("FAIL be_second: got valid=%0b inst=%h pc=%h want 1 0001 0", b_inst_valid, b_inst, b_inst_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_queue_full();
        test_busy();
        test_jump();
        test_rdy_hold();
        test_big_endian();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
